fetch_ctrl: RTL and testbench

Fetch sequencer for the MIPS pipeline. It drives the PC register's `NPC` and `stall` inputs and runs the request/acknowledge handshake with instruction memory. It merges branch, jump, exception and `eret` redirects into one next-PC choice and buffers any redirect that arrives while a fetch is still outstanding. It sits between the decode-stage branch unit, the hazard unit, CP0, IM and the PC register.

---
 rtl/fetch_ctrl_pkg.sv | 33 +++
 rtl/fetch_ctrl_if.sv | 30 +++
 rtl/fetch_ctrl_redirect_buffer.sv | 57 +++++
 rtl/fetch_ctrl.sv | 113 +++++++++++
 tb/tb_fetch_ctrl.sv | 171 +++++++++++++++++
 5 files changed

// File: rtl/fetch_ctrl_pkg.sv
// Shared types and defaults for the fetch sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package fetch_ctrl_pkg;

    localparam logic [31:0] RESET_PC_DEF = 32'h0000_3000;
    localparam logic [31:0] EXC_VEC_DEF  = 32'h0000_4180;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    // Numeric order is the redirect priority: a larger value wins.
    typedef enum logic [1:0] {
        RD_NONE = 2'd0,
        RD_BR   = 2'd1,
        RD_ERET = 2'd2,
        RD_EXC  = 2'd3
    } rd_kind_t;

    typedef struct packed {
        rd_kind_t    kind;
        logic [31:0] target;
    } redirect_t;

    // EXC and ERET both discard the fetched instruction and may be applied from HOLD.
    function automatic logic is_exc_class(input rd_kind_t k);
        return (k == RD_EXC) || (k == RD_ERET);
    endfunction

endpackage

// File: rtl/fetch_ctrl_if.sv
// Bundle of the fetch sequencer's pipeline, CP0 and IM signals.
// Latency: n/a (wiring only).
// Backpressure: IM stalls the sequencer by withholding im_ack.
interface fetch_ctrl_if;
    logic [31:0] pc;
    logic        hazard_stall;
    logic        br_taken;
    logic [31:0] br_target;
    logic        exc_req;
    logic        eret_req;
    logic [31:0] epc;
    logic        im_ack;
    logic        im_req;
    logic [31:0] npc;
    logic        pc_stall;
    logic        if_flush;
    logic        redirect_pending;

    // master: the fetch sequencer itself
    modport master (
        input  pc, hazard_stall, br_taken, br_target, exc_req, eret_req, epc, im_ack,
        output im_req, npc, pc_stall, if_flush, redirect_pending
    );

    // slave: the surrounding pipeline / memory side
    modport slave (
        output pc, hazard_stall, br_taken, br_target, exc_req, eret_req, epc, im_ack,
        input  im_req, npc, pc_stall, if_flush, redirect_pending
    );
endinterface

// File: rtl/fetch_ctrl_redirect_buffer.sv
// Single-entry redirect buffer with priority merge of stored and incoming redirects.
// Latency: effective redirect is combinational; stored entry updates next cycle.
// Backpressure: none; lower-priority arrivals are dropped while a higher one is held.
module redirect_buffer
    import fetch_ctrl_pkg::*;
#(
    parameter logic [31:0] EXC_VEC = EXC_VEC_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        exc_req,
    input  logic        eret_req,
    input  logic [31:0] epc,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    input  logic        clear,
    output redirect_t   eff,
    output logic        pend_vld
);

    redirect_t pend_q;
    redirect_t in_c;

    // Encode this cycle's events; EXC beats ERET beats BR when they coincide.
    always_comb begin
        in_c = '{kind: RD_NONE, target: 32'h0};
        if (exc_req) begin
            in_c = '{kind: RD_EXC, target: EXC_VEC};
        end else if (eret_req) begin
            in_c = '{kind: RD_ERET, target: epc};
        end else if (br_taken) begin
            in_c = '{kind: RD_BR, target: br_target};
        end
    end

    // Incoming event replaces the stored one on equal or higher priority.
    always_comb begin
        eff = pend_q;
        if ((in_c.kind != RD_NONE) && (in_c.kind >= pend_q.kind)) begin
            eff = in_c;
        end
    end

    // Hold the merged redirect until the sequencer applies it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend_q <= '{kind: RD_NONE, target: 32'h0};
        end else if (clear) begin
            pend_q <= '{kind: RD_NONE, target: 32'h0};
        end else begin
            pend_q <= eff;
        end
    end

    assign pend_vld = (pend_q.kind != RD_NONE);

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch sequencer: IM request handshake, next-PC selection and redirect merging.
// Latency: npc/pc_stall combinational; one instruction per cycle while im_ack stays high.
// Backpressure: im_ack low or hazard_stall high freeze the PC (pc_stall=1).
module fetch_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF,
    parameter logic [31:0] EXC_VEC  = EXC_VEC_DEF
) (
    input  logic          clk,
    input  logic          reset,
    fetch_ctrl_if.master  bus
);

    state_t      state_q;
    state_t      state_nxt;
    redirect_t   eff;
    logic        pend_vld;
    logic        clear;
    logic        pc_stall_c;
    logic        if_flush_c;
    logic [31:0] npc_c;
    logic [31:0] pc_inc;

    assign pc_inc = bus.pc + 32'd4;

    redirect_buffer #(
        .EXC_VEC (EXC_VEC)
    ) u_rbuf (
        .clk       (clk),
        .reset     (reset),
        .exc_req   (bus.exc_req),
        .eret_req  (bus.eret_req),
        .epc       (bus.epc),
        .br_taken  (bus.br_taken),
        .br_target (bus.br_target),
        .clear     (clear),
        .eff       (eff),
        .pend_vld  (pend_vld)
    );

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    // Next state, next PC and redirect application.
    always_comb begin
        state_nxt  = state_q;
        pc_stall_c = 1'b1;
        npc_c      = bus.pc;
        if_flush_c = 1'b0;
        clear      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                state_nxt = ST_REQ;
            end
            ST_REQ: begin
                if (bus.im_ack) begin
                    if (is_exc_class(eff.kind)) begin
                        pc_stall_c = 1'b0;
                        npc_c      = eff.target;
                        if_flush_c = 1'b1;
                        clear      = 1'b1;
                    end else if (bus.hazard_stall) begin
                        // Same pc is re-fetched once the hazard clears.
                        state_nxt = ST_HOLD;
                    end else if (eff.kind == RD_BR) begin
                        // Delay-slot instruction is kept, so no flush.
                        pc_stall_c = 1'b0;
                        npc_c      = eff.target;
                        clear      = 1'b1;
                    end else begin
                        pc_stall_c = 1'b0;
                        npc_c      = pc_inc;
                    end
                end
            end
            ST_HOLD: begin
                if (is_exc_class(eff.kind)) begin
                    pc_stall_c = 1'b0;
                    npc_c      = eff.target;
                    if_flush_c = 1'b1;
                    clear      = 1'b1;
                    state_nxt  = ST_REQ;
                end else if (!bus.hazard_stall) begin
                    state_nxt = ST_REQ;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
        // While reset is held the PC register sees its own reset value.
        if (reset) begin
            npc_c      = RESET_PC;
            pc_stall_c = 1'b1;
            if_flush_c = 1'b0;
            clear      = 1'b1;
        end
    end

    assign bus.im_req           = (state_q == ST_REQ);
    assign bus.npc              = npc_c;
    assign bus.pc_stall         = pc_stall_c;
    assign bus.if_flush         = if_flush_c;
    assign bus.redirect_pending = pend_vld;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl with hand-computed expectations.
// Latency: outputs sampled on the falling edge after inputs settle.
// Backpressure: im_ack and hazard_stall driven directly by the vectors.
module tb_fetch_ctrl;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_err;

    fetch_ctrl_if bus ();

    fetch_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Compare all observable outputs against one expected vector.
    task automatic expect_out(input string tag, input logic req, input logic stall,
                              input logic [31:0] npc, input logic flush, input logic pend);
        chk({tag, ".im_req"},   {31'b0, bus.im_req},           {31'b0, req});
        chk({tag, ".pc_stall"}, {31'b0, bus.pc_stall},         {31'b0, stall});
        chk({tag, ".npc"},      bus.npc,                       npc);
        chk({tag, ".if_flush"}, {31'b0, bus.if_flush},         {31'b0, flush});
        chk({tag, ".pending"},  {31'b0, bus.redirect_pending}, {31'b0, pend});
    endtask

    task automatic drive(input logic [31:0] pc, input logic ack, input logic hz,
                         input logic br, input logic [31:0] brt,
                         input logic exc, input logic eret, input logic [31:0] epc);
        bus.pc           = pc;
        bus.im_ack       = ack;
        bus.hazard_stall = hz;
        bus.br_taken     = br;
        bus.br_target    = brt;
        bus.exc_req      = exc;
        bus.eret_req     = eret;
        bus.epc          = epc;
    endtask

    // Advance past the next rising edge, apply a vector, then sample at the falling edge.
    task automatic step(input logic [31:0] pc, input logic ack, input logic hz,
                        input logic br, input logic [31:0] brt,
                        input logic exc, input logic eret, input logic [31:0] epc);
        @(posedge clk);
        #1;
        drive(pc, ack, hz, br, brt, exc, eret, epc);
        @(negedge clk);
    endtask

    initial begin
        n_checks = 0;
        n_err    = 0;
        reset    = 1'b1;
        drive(32'h0000_1234, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        // npc must show the reset vector even though pc differs
        expect_out("reset", 1'b0, 1'b1, 32'h0000_3000, 1'b0, 1'b0);

        // Release reset: IDLE cycle
        @(posedge clk);
        #1;
        reset = 1'b0;
        drive(32'h0000_3000, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        expect_out("idle", 1'b0, 1'b1, 32'h0000_3000, 1'b0, 1'b0);

        // Back-to-back acks: sequential fetch
        step(32'h0000_3000, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        expect_out("seq0", 1'b1, 1'b0, 32'h0000_3004, 1'b0, 1'b0);

        // Ack delayed three cycles
        for (int i = 0; i < 3; i++) begin
            step(32'h0000_3004, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
            expect_out("wait", 1'b1, 1'b1, 32'h0000_3004, 1'b0, 1'b0);
        end
        step(32'h0000_3004, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        expect_out("late_ack", 1'b1, 1'b0, 32'h0000_3008, 1'b0, 1'b0);

        // Branch during an ack wait is buffered and applied on ack without flush
        step(32'h0000_3008, 1'b0, 1'b0, 1'b1, 32'h0000_3100, 1'b0, 1'b0, 32'h0);
        expect_out("br_in", 1'b1, 1'b1, 32'h0000_3008, 1'b0, 1'b0);
        step(32'h0000_3008, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        expect_out("br_pend", 1'b1, 1'b1, 32'h0000_3008, 1'b0, 1'b1);
        step(32'h0000_3008, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        expect_out("br_apply", 1'b1, 1'b0, 32'h0000_3100, 1'b0, 1'b1);

        // Ack under hazard stall -> HOLD; pending must be clear now
        step(32'h0000_3100, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        expect_out("to_hold", 1'b1, 1'b1, 32'h0000_3100, 1'b0, 1'b0);
        step(32'h0000_3100, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        expect_out("hold", 1'b0, 1'b1, 32'h0000_3100, 1'b0, 1'b0);
        // Exception in HOLD is applied immediately
        step(32'h0000_3100, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        expect_out("hold_exc", 1'b0, 1'b0, 32'h0000_4180, 1'b1, 1'b0);

        // Back in REQ: pending branch superseded by a later exception
        step(32'h0000_4180, 1'b0, 1'b0, 1'b1, 32'h0000_3100, 1'b0, 1'b0, 32'h0);
        expect_out("req_br", 1'b1, 1'b1, 32'h0000_4180, 1'b0, 1'b0);
        step(32'h0000_4180, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        expect_out("exc_in", 1'b1, 1'b1, 32'h0000_4180, 1'b0, 1'b1);
        step(32'h0000_4180, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        expect_out("exc_over_br", 1'b1, 1'b0, 32'h0000_4180, 1'b1, 1'b1);

        // Simultaneous exc and eret: exception wins, eret is not retained
        step(32'h0000_4180, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h0000_3008);
        expect_out("exc_eret", 1'b1, 1'b0, 32'h0000_4180, 1'b1, 1'b0);
        // Eret alone on an ack cycle
        step(32'h0000_4180, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0000_3008);
        expect_out("eret", 1'b1, 1'b0, 32'h0000_3008, 1'b1, 1'b0);
        step(32'h0000_3008, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        expect_out("after_eret", 1'b1, 1'b0, 32'h0000_300C, 1'b0, 1'b0);

        // Stored eret keeps priority over a later branch
        step(32'h0000_300C, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0000_5000);
        expect_out("eret_in", 1'b1, 1'b1, 32'h0000_300C, 1'b0, 1'b0);
        step(32'h0000_300C, 1'b0, 1'b0, 1'b1, 32'h0000_3100, 1'b0, 1'b0, 32'h0);
        expect_out("br_drop", 1'b1, 1'b1, 32'h0000_300C, 1'b0, 1'b1);
        step(32'h0000_300C, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        expect_out("eret_apply", 1'b1, 1'b0, 32'h0000_5000, 1'b1, 1'b1);

        // HOLD released by hazard_stall dropping
        step(32'h0000_5000, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        expect_out("hold2_in", 1'b1, 1'b1, 32'h0000_5000, 1'b0, 1'b0);
        step(32'h0000_5000, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        expect_out("hold_rel", 1'b0, 1'b1, 32'h0000_5000, 1'b0, 1'b0);
        step(32'h0000_5000, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        expect_out("refetch", 1'b1, 1'b1, 32'h0000_5000, 1'b0, 1'b0);

        // 32-bit wrap of pc+4
        step(32'hFFFF_FFFC, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        expect_out("wrap", 1'b1, 1'b0, 32'h0000_0000, 1'b0, 1'b0);

        // Load a pending branch, then assert reset mid-cycle with an ack present
        step(32'h0000_0000, 1'b0, 1'b0, 1'b1, 32'h0000_3100, 1'b0, 1'b0, 32'h0);
        expect_out("pre_rst", 1'b1, 1'b1, 32'h0000_0000, 1'b0, 1'b0);
        step(32'h0000_0000, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        expect_out("pre_rst_pend", 1'b1, 1'b1, 32'h0000_0000, 1'b0, 1'b1);
        @(posedge clk);
        #2;
        drive(32'h0000_0000, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        reset = 1'b1;
        #1;
        expect_out("mid_rst", 1'b0, 1'b1, 32'h0000_3000, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        drive(32'h0000_3000, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        // IDLE ignores the ack
        expect_out("post_rst", 1'b0, 1'b1, 32'h0000_3000, 1'b0, 1'b0);
        step(32'h0000_3000, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        expect_out("post_rst_req", 1'b1, 1'b0, 32'h0000_3004, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
